aes_sbox_share_ctrl: RTL and testbench
======================================

Name: aes_sbox_share_ctrl

Overview:
- Time-multiplexes one bank of LANES AES S-box lookups (AesSboxFun instances) between two requesters.
- Requesters: the round datapath (128-bit SubBytes) and the key expansion (32-bit SubWord).
- Each requester has a valid/ready input handshake, and arbitration is at transaction granularity.
- Results are registered and returned with a one-cycle valid pulse. Sits between the round FSM/key schedule and the shared S-box bank.

Parameters:
- LANES, 4, number of S-box instances used per cycle; legal values are 1, 2 and 4.
- KEY_PRIORITY, 0, tie-break rule: 0 = round-robin; 1 = key requester always wins.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- dataValid  in  1  SubBytes request
- dataReady  out  1  SubBytes request accepted this cycle
- dataIn  in  128  state; byte i = bits [8i+7:8i]
- dataOutValid  out  1  one-cycle pulse: dataOut updated
- dataOut  out  128  SubBytes result
- keyValid  in  1  SubWord request
- keyReady  out  1  SubWord request accepted this cycle
- keyIn  in  32  word; byte i = bits [8i+7:8i]
- keyOutValid  out  1  one-cycle pulse: keyOut updated
- keyOut  out  32  SubWord result
- busy  out  1  high while a transaction is in progress (state != IDLE)

Behaviour:
- Reset: the async assert of rst forces the following.
  - state=IDLE, beat counter=0, lastGrant=KEY.
  - dataOut=0, keyOut=0, dataOutValid=0, keyOutValid=0, busy=0.
  - dataReady and keyReady are forced 0 while rst is high.
- Reset mid-transaction: the partial result is discarded, no valid pulse is issued, and the requester must re-issue.
- FSM states: IDLE, DATA, KEY.
- IDLE, grant selection:
  - If only one valid is high, that requester is granted.
  - If both are high and KEY_PRIORITY=1, KEY is granted.
  - If both are high and KEY_PRIORITY=0, the requester not equal to lastGrant is granted.
- IDLE, ready: dataReady/keyReady are combinational and equal (state==IDLE && !rst && grant==X). At most one ready is high in any cycle.
- Handshake edge (valid&&ready):
  - The input is captured into an internal operand register.
  - lastGrant is set to the granted requester, beat counter=0, and state goes to DATA or KEY.
- Beats:
  - N = 16/LANES for DATA and 4/LANES for KEY.
  - On beat b (b=0..N-1), lane k looks up operand byte b*LANES+k. The result is written to byte b*LANES+k of an internal result register.
  - The counter increments each cycle with no stalls.
  - Unused lanes are driven 8'h00 and their results ignored.
- Completion:
  - On the edge that completes beat N-1, the result register is copied to dataOut/keyOut and the matching OutValid is set for exactly one cycle.
  - On that same edge the state returns to IDLE, so a new handshake can occur in the cycle the OutValid pulse is high.
- Latency: N cycles from handshake edge to OutValid high.
  - LANES=4: DATA 4 cycles, KEY 1 cycle.
  - LANES=1: DATA 16 cycles, KEY 4 cycles.
- Output hold: dataOut/keyOut hold their last value until overwritten by the same requester's next completion. A completion of one requester never alters the other requester's output.
- No output backpressure: the consumer must sample on the OutValid pulse.
- Request hold: requesters hold valid and operand stable until ready. The operand is sampled only at the handshake edge, so later input changes have no effect.
- Ready is never asserted while busy, so requests that arrive in DATA/KEY wait in IDLE.
- Back-to-back: with both valids held high and KEY_PRIORITY=0, grants alternate DATA, KEY, DATA, ... with no idle cycle between transactions.

Test Plan:
- Reset release, both valids high, LANES=4, dataIn=128'h0F0E0D0C0B0A09080706050403020100 → DATA is granted first (lastGrant reset=KEY). dataOut=128'h76ABD7FE2B670130C56F6BF27B777C63 with dataOutValid 4 cycles after the handshake. KEY is then granted in the same cycle as the pulse.
- keyIn=32'h00000053 alone, LANES=4 → keyReady the same cycle; keyOut=32'h636363ED with keyOutValid 1 cycle later; dataOut unchanged.
- LANES=1, same data vector → 16-cycle latency, identical result; busy high for exactly 16 cycles.
- KEY_PRIORITY=1, both valids held for 3 transactions → grant order KEY, KEY, KEY; dataReady stays 0 throughout.
- Assert rst two beats into a DATA transaction (LANES=1) → outputs zero immediately, no dataOutValid, state IDLE. After release a new request completes normally.
- Change dataIn from vector A to vector B the cycle after the handshake → the result corresponds to vector A; the one-cycle OutValid pulse occurs exactly once.

Source files
------------

// File: rtl/aes_sbox_share_ctrl_if.sv
// rtl/aes_sbox_share_ctrl_if.sv - request/response bundle between the two requesters and the shared S-box controller
interface aes_sbox_share_ctrl_if;
  logic         dataValid;
  logic         dataReady;
  logic [127:0] dataIn;
  logic         dataOutValid;
  logic [127:0] dataOut;
  logic         keyValid;
  logic         keyReady;
  logic [31:0]  keyIn;
  logic         keyOutValid;
  logic [31:0]  keyOut;
  logic         busy;

  modport master (
    output dataValid, dataIn, keyValid, keyIn,
    input  dataReady, dataOutValid, dataOut, keyReady, keyOutValid, keyOut, busy
  );

  modport slave (
    input  dataValid, dataIn, keyValid, keyIn,
    output dataReady, dataOutValid, dataOut, keyReady, keyOutValid, keyOut, busy
  );
endinterface

// File: rtl/aes_sbox_share_ctrl.sv
// rtl/aes_sbox_share_ctrl.sv - shares LANES AES S-boxes between SubBytes and SubWord requesters
module aes_sbox_share_ctrl #(
  parameter int LANES        = 4,
  parameter bit KEY_PRIORITY = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  aes_sbox_share_ctrl_if.slave bus
);

  localparam int N_DATA = 16 / LANES;
  localparam int N_KEY  = 4 / LANES;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_KEY} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 followed by the AES affine transform.
  function automatic logic [7:0] aes_sbox_fun(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t       state, state_next;
  logic [3:0]   cnt;
  logic         last_grant;
  logic [127:0] op_reg;
  logic [127:0] res_reg;
  logic [127:0] res_next;
  logic [127:0] data_out;
  logic [31:0]  key_out;
  logic         data_out_valid;
  logic         key_out_valid;
  logic         grant_key;
  logic         grant_data;
  logic         data_ready;
  logic         key_ready;
  logic         hs_data;
  logic         hs_key;
  logic         last_beat;

  // last_grant: 1 = KEY, 0 = DATA
  assign grant_key  = bus.keyValid && (!bus.dataValid || KEY_PRIORITY || !last_grant);
  assign grant_data = bus.dataValid && !grant_key;
  assign hs_data    = bus.dataValid && data_ready;
  assign hs_key     = bus.keyValid && key_ready;
  assign last_beat  = (state == S_DATA) ? (cnt == 4'(N_DATA - 1)) : (cnt == 4'(N_KEY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (hs_data)     state_next = S_DATA;
        else if (hs_key) state_next = S_KEY;
      end
      S_DATA, S_KEY: if (last_beat) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    data_ready = (state == S_IDLE) && !rst && grant_data;
    key_ready  = (state == S_IDLE) && !rst && grant_key;
  end

  always_comb begin
    res_next = res_reg;
    for (int k = 0; k < LANES; k++) begin
      res_next[7'((int'(cnt) * LANES + k) * 8) +: 8] =
        aes_sbox_fun(op_reg[7'((int'(cnt) * LANES + k) * 8) +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= 4'd0;
      last_grant     <= 1'b1;
      op_reg         <= '0;
      res_reg        <= '0;
      data_out       <= '0;
      key_out        <= '0;
      data_out_valid <= 1'b0;
      key_out_valid  <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      key_out_valid  <= 1'b0;
      if (state == S_IDLE) begin
        if (hs_data) begin
          op_reg     <= bus.dataIn;
          last_grant <= 1'b0;
          cnt        <= 4'd0;
        end else if (hs_key) begin
          op_reg     <= {96'h0, bus.keyIn};
          last_grant <= 1'b1;
          cnt        <= 4'd0;
        end
      end else begin
        res_reg <= res_next;
        cnt     <= cnt + 4'd1;
        if (last_beat) begin
          cnt <= 4'd0;
          if (state == S_DATA) begin
            data_out       <= res_next;
            data_out_valid <= 1'b1;
          end else begin
            key_out        <= res_next[31:0];
            key_out_valid  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.dataReady    = data_ready;
  assign bus.keyReady     = key_ready;
  assign bus.dataOut      = data_out;
  assign bus.keyOut       = key_out;
  assign bus.dataOutValid = data_out_valid;
  assign bus.keyOutValid  = key_out_valid;
  assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_aes_sbox_share_ctrl.sv
// tb/tb_aes_sbox_share_ctrl.sv - scoreboard bench for the shared S-box controller
module tb_aes_sbox_share_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_sbox_share_ctrl_if i4();
  aes_sbox_share_ctrl_if i1();
  aes_sbox_share_ctrl_if ik();

  aes_sbox_share_ctrl #(.LANES(4), .KEY_PRIORITY(1'b0)) u4 (.clk(clk), .rst(rst), .bus(i4.slave));
  aes_sbox_share_ctrl #(.LANES(1), .KEY_PRIORITY(1'b0)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  aes_sbox_share_ctrl #(.LANES(4), .KEY_PRIORITY(1'b1)) uk (.clk(clk), .rst(rst), .bus(ik.slave));

  localparam logic [127:0] VA   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] VA_R = 128'h76ABD7FE2B670130C56F6BF27B777C63;
  localparam logic [127:0] VC   = {16{8'h53}};
  localparam logic [127:0] VC_R = {16{8'hED}};
  localparam logic [31:0]  K1   = 32'h00000053;
  localparam logic [31:0]  K1_R = 32'h636363ED;
  localparam logic [31:0]  K2   = 32'h0F0E0D0C;
  localparam logic [31:0]  K2_R = 32'h76ABD7FE;
  localparam logic [31:0]  K3   = 32'h53535353;
  localparam logic [31:0]  K3_R = 32'hEDEDEDED;

  logic [127:0] qd4[$], qd1[$], qdk[$];
  logic [31:0]  qk4[$], qk1[$], qkk[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%h required=no pulse", name, act);
  endtask

  always @(negedge clk) begin
    if (i4.dataOutValid) begin
      if (qd4.size() == 0) unexpected("d4_data_pulse", i4.dataOut);
      else check("d4_data", i4.dataOut, qd4.pop_front());
    end
    if (i4.keyOutValid) begin
      if (qk4.size() == 0) unexpected("d4_key_pulse", {96'h0, i4.keyOut});
      else check("d4_key", {96'h0, i4.keyOut}, {96'h0, qk4.pop_front()});
    end
    if (i1.dataOutValid) begin
      if (qd1.size() == 0) unexpected("d1_data_pulse", i1.dataOut);
      else check("d1_data", i1.dataOut, qd1.pop_front());
    end
    if (i1.keyOutValid) begin
      if (qk1.size() == 0) unexpected("d1_key_pulse", {96'h0, i1.keyOut});
      else check("d1_key", {96'h0, i1.keyOut}, {96'h0, qk1.pop_front()});
    end
    if (ik.dataOutValid) begin
      if (qdk.size() == 0) unexpected("dk_data_pulse", ik.dataOut);
      else check("dk_data", ik.dataOut, qdk.pop_front());
    end
    if (ik.keyOutValid) begin
      if (qkk.size() == 0) unexpected("dk_key_pulse", {96'h0, ik.keyOut});
      else check("dk_key", {96'h0, ik.keyOut}, {96'h0, qkk.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, busy_cnt, grants, dr_seen, pulses;
    logic [31:0] kin[3];
    logic [31:0] kexp[3];
    kin  = '{K1, K2, K3};
    kexp = '{K1_R, K2_R, K3_R};

    i1.dataValid = 0; i1.dataIn = '0; i1.keyValid = 0; i1.keyIn = '0;
    ik.dataValid = 0; ik.dataIn = '0; ik.keyValid = 0; ik.keyIn = '0;
    i4.dataValid = 1; i4.dataIn = VA; i4.keyValid = 1; i4.keyIn = K1;

    // reset state with both requests pending
    repeat (2) @(posedge clk);
    #1;
    check("rst_dataOut", i4.dataOut, 0);
    check("rst_keyOut", {96'h0, i4.keyOut}, 0);
    check("rst_valids", {i4.dataOutValid, i4.keyOutValid}, 0);
    check("rst_busy", i4.busy, 0);
    check("rst_readies", {i4.dataReady, i4.keyReady}, 0);

    // DATA wins first after reset, KEY granted in the pulse cycle
    rst = 0;
    #1;
    check("first_grant", {i4.dataReady, i4.keyReady}, 2'b10);
    qd4.push_back(VA_R);
    qk4.push_back(K1_R);
    @(posedge clk); #1;
    check("busy_no_ready", {i4.busy, i4.dataReady, i4.keyReady}, 3'b100);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!i4.dataOutValid && lat < 40);
    check("d4_data_latency", lat, 4);
    check("key_b2b_ready", i4.keyReady, 1);
    i4.dataValid = 0;
    @(posedge clk); #1;
    i4.keyValid = 0;
    check("key_busy", i4.busy, 1);
    @(posedge clk); #1;
    check("key_lat1_pulse", i4.keyOutValid, 1);

    // key alone
    i4.keyValid = 1; i4.keyIn = K2;
    #1;
    check("key_alone_ready", i4.keyReady, 1);
    qk4.push_back(K2_R);
    @(posedge clk); #1;
    i4.keyValid = 0;
    check("key_alone_pending", i4.keyOutValid, 0);
    @(posedge clk); #1;
    check("key_alone_pulse", i4.keyOutValid, 1);
    check("dataOut_held", i4.dataOut, VA_R);

    // LANES=1 SubBytes
    i1.dataValid = 1; i1.dataIn = VA;
    #1;
    check("d1_ready", i1.dataReady, 1);
    qd1.push_back(VA_R);
    @(posedge clk); #1;
    i1.dataValid = 0;
    busy_cnt = 0; lat = 0;
    do begin
      if (i1.busy) busy_cnt++;
      @(posedge clk); #1; lat++;
    end while (!i1.dataOutValid && lat < 40);
    check("d1_latency", lat, 16);
    check("d1_busy_cycles", busy_cnt, 16);
    check("d1_idle_at_pulse", i1.busy, 0);

    // key priority: three key grants while data is also pending
    ik.dataValid = 1; ik.dataIn = VC; ik.keyValid = 1; ik.keyIn = kin[0];
    #1;
    grants = 0; dr_seen = 0;
    for (int cyc = 0; cyc < 100 && grants < 3; cyc++) begin
      if (ik.dataReady) dr_seen++;
      if (ik.keyReady) begin
        qkk.push_back(kexp[grants]);
        grants++;
        @(posedge clk); #1;
        if (grants < 3) ik.keyIn = kin[grants];
        else ik.keyValid = 0;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("prio_grants", grants, 3);
    check("prio_no_data_ready", dr_seen, 0);
    for (int cyc = 0; cyc < 20 && !ik.dataReady; cyc++) begin @(posedge clk); #1; end
    check("prio_data_after", ik.dataReady, 1);
    qdk.push_back(VC_R);
    @(posedge clk); #1;
    ik.dataValid = 0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ik.dataOutValid && lat < 40);
    check("dk_data_latency", lat, 4);

    // reset two beats into a LANES=1 transaction
    i1.dataValid = 1; i1.dataIn = VC;
    #1;
    check("d1_rst_ready", i1.dataReady, 1);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    #1;
    check("mid_rst_dataOut", i1.dataOut, 0);
    check("mid_rst_state", {i1.busy, i1.dataOutValid, i1.dataReady}, 0);
    check("mid_rst_other", {96'h0, i4.keyOut}, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("post_rst_ready", i1.dataReady, 1);
    qd1.push_back(VC_R);
    @(posedge clk); #1;
    i1.dataValid = 0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!i1.dataOutValid && lat < 40);
    check("post_rst_latency", lat, 16);

    // operand captured only at handshake
    i4.dataValid = 1; i4.dataIn = VA;
    #1;
    check("cap_ready", i4.dataReady, 1);
    qd4.push_back(VA_R);
    @(posedge clk); #1;
    i4.dataIn = VB_INV();
    i4.dataValid = 0;
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (i4.dataOutValid) pulses++; end
    check("cap_single_pulse", pulses, 1);

    check("queues_drained", qd4.size() + qk4.size() + qd1.size() + qk1.size() + qdk.size() + qkk.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [127:0] VB_INV();
    return VC;
  endfunction

endmodule
